vga_sync_buf: RTL

Video output stage that consumes the pixel stream produced by the frame-counter-driven pixel pipeline and drives the VGA connector. Contains a pixel-tick divider, horizontal/vertical raster counters with porch/sync timing, and a small pixel FIFO. Emits `frame_sync` to upstream; the pipeline uses it as `sync_clr` for its frame counter, so upstream pixel generation stays locked to the raster.

---
 rtl/vga_sync_buf_pkg.sv | 25 ++
 rtl/vga_sync_buf_if.sv | 13 +
 rtl/vga_sync_buf_pixel_fifo.sv | 49 ++++
 rtl/vga_sync_buf.sv | 109 ++++++++++
 4 files changed

// File: rtl/vga_sync_buf_pkg.sv
// Shared types, default VGA 640x480 timing and sizing helpers for the video output stage.
package vga_pkg;
  localparam int CD_DEF         = 12;
  localparam int HD_DEF         = 640;
  localparam int HF_DEF         = 16;
  localparam int HS_DEF         = 96;
  localparam int HB_DEF         = 48;
  localparam int VD_DEF         = 480;
  localparam int VF_DEF         = 10;
  localparam int VS_DEF         = 2;
  localparam int VB_DEF         = 33;
  localparam int CLK_DIV_DEF    = 4;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef logic [CD_DEF-1:0] rgb_t;

  function automatic int total(input int d, input int f, input int s, input int b);
    return d + f + s + b;
  endfunction

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/vga_sync_buf_if.sv
// Upstream pixel stream: valid/ready handshake carrying one pixel per beat.
interface vga_sync_buf_if
  import vga_pkg::*;
#(
  parameter int CD = CD_DEF
);
  logic [CD-1:0] rgb;
  logic          valid;
  logic          ready;

  modport master (output rgb, output valid, input ready);
  modport slave  (input rgb, input valid, output ready);
endinterface

// File: rtl/vga_sync_buf_pixel_fifo.sv
// Register-based synchronous pixel FIFO with push/pop/flush; head is readable the cycle after push.
module pixel_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/vga_sync_buf.sv
// VGA output stage: pixel-tick divider, raster counters, sync decode and a pixel FIFO
// that is flushed at the start of vertical blanking so upstream can re-lock to the raster.
module vga_sync_buf
  import vga_pkg::*;
#(
  parameter int CD         = CD_DEF,
  parameter int HD         = HD_DEF,
  parameter int HF         = HF_DEF,
  parameter int HS         = HS_DEF,
  parameter int HB         = HB_DEF,
  parameter int VD         = VD_DEF,
  parameter int VF         = VF_DEF,
  parameter int VS         = VS_DEF,
  parameter int VB         = VB_DEF,
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_sync_buf_if.slave       s,
  output logic                frame_sync,
  output logic                hsync,
  output logic                vsync,
  output logic [CD-1:0]       rgb,
  output logic                underflow
);
  localparam int HT = total(HD, HF, HS, HB);
  localparam int VT = total(VD, VF, VS, VB);
  localparam int HW = cnt_w(HT);
  localparam int VW = cnt_w(VT);
  localparam int DW = cnt_w(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
  localparam logic [HW-1:0] H_DISP   = HW'(HD);
  localparam logic [HW-1:0] HS_BEG   = HW'(HD + HF);
  localparam logic [HW-1:0] HS_END   = HW'(HD + HF + HS - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
  localparam logic [VW-1:0] V_DISP   = VW'(VD);
  localparam logic [VW-1:0] VS_BEG   = VW'(VD + VF);
  localparam logic [VW-1:0] VS_END   = VW'(VD + VF + VS - 1);

  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          tick, video_on, flush, push, pop, ready;
  logic          full, empty;
  logic [CD-1:0] head;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  assign video_on = (h < H_DISP) && (v < V_DISP);
  assign flush    = tick && (h == '0) && (v == V_DISP);
  assign pop      = tick && video_on && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts then.
  assign ready    = !(full && !pop) && !flush;
  assign push     = s.valid && ready;
  assign s.ready  = ready;

  pixel_fifo #(.W(CD), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (s.rgb),
    .pop   (pop),
    .flush (flush),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Outputs describe the pixel held before the tick edge, keeping sync and colour aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rgb        <= '0;
      frame_sync <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      frame_sync <= flush;
      if (tick) begin
        hsync <= !((h >= HS_BEG) && (h <= HS_END));
        vsync <= !((v >= VS_BEG) && (v <= VS_END));
        rgb   <= pop ? head : '0;
      end
      if (tick && video_on && empty) underflow <= 1'b1;
      else if (frame_sync)           underflow <= 1'b0;
    end
  end
endmodule
